// File: rtl/uart_ring_tx.sv
// rtl/uart_ring_tx.sv - 8N1 UART transmitter fed from a ring buffer.
// Optional even-parity bit (8E1/8E2) is enabled by defining UART_TX_PARITY_EN.
module uart_ring_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txEnable,
    output logic       dataReadReq,
    input  logic       dataReadAck,
    input  logic [7:0] dataRead,
    output logic       tx,
    output logic       busy,
    output logic       frameDone
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_FETCH, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_FETCH, ST_START, ST_DATA, ST_STOP
    } state_t;
`endif

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic          stop_idx_q;
    logic [7:0]    shift_q;
    logic          req_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    assign dataReadReq = req_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frameDone   = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            req_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FETCH: begin
                    done_q <= 1'b0;
                    tx_q   <= 1'b1;
                    // An ack only counts against a request already on the wire.
                    if (req_q && dataReadAck) begin
                        shift_q <= dataRead;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^dataRead;
`endif
                        busy_q  <= 1'b1;
                        req_q   <= 1'b0;
                        tx_q    <= 1'b0;
                        baud_q  <= '0;
                        state_q <= ST_START;
                    end else begin
                        busy_q <= 1'b0;
                        req_q  <= txEnable;
                    end
                end
                ST_START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
`else
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                            state_q    <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q     <= '0;
                        tx_q       <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (stop_idx_q == STOP_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ring_tx.sv
// tb/tb_uart_ring_tx.sv - scoreboard bench for uart_ring_tx against a bit-level frame model.
module tb_uart_ring_tx;

    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 10 + SB;
`else
    localparam int NBITS = 9 + SB;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic       clk;
    logic       reset;
    logic       txEnable;
    logic       dataReadReq;
    logic       dataReadAck;
    logic [7:0] dataRead;
    logic       tx;
    logic       busy;
    logic       frameDone;

    int tests;
    int fails;
    int cyc;

    logic [7:0] buf_q[$];
    logic [7:0] exp_q[$];
    int         fall_log[$];
    int         done_log[$];
    bit         ack_always;
    bit         rand_ack;
    logic       prev_tx;

    uart_ring_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk        (clk),
        .reset      (reset),
        .txEnable   (txEnable),
        .dataReadReq(dataReadReq),
        .dataReadAck(dataReadAck),
        .dataRead   (dataRead),
        .tx         (tx),
        .busy       (busy),
        .frameDone  (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Line level of frame bit slot i: start, data LSB first, optional parity, then stop/idle.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic run_frame();
        logic [7:0] b;
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        fall_log.push_back(cyc);
        for (int k = 0; k <= FRAME_LEN + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (reset) return;
            chk($sformatf("tx_b%02h_k%0d", b, k), tx, frame_bit(b, k / CPB));
            chk($sformatf("frameDone_k%0d", k), frameDone, (k == FRAME_LEN));
            chk($sformatf("busy_k%0d", k), busy, (k <= FRAME_LEN));
            if (k == FRAME_LEN) done_log.push_back(cyc);
        end
    endtask

    initial begin : monitor
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_tx = 1'b1;
            end else if (prev_tx && !tx) begin
                run_frame();
                prev_tx = tx;
            end else begin
                if (frameDone || busy) chk("idle_stray_busy_done", {busy, frameDone}, 0);
                prev_tx = tx;
            end
        end
    end

    initial begin : buffer_model
        dataReadAck = 1'b0;
        dataRead    = 8'h00;
        forever begin
            @(negedge clk);
            dataReadAck = 1'b0;
            dataRead    = 8'($urandom);
            if (!reset && buf_q.size() != 0 && (dataReadReq || ack_always) &&
                (!rand_ack || $urandom_range(0, 2) == 0)) begin
                dataReadAck = 1'b1;
                dataRead    = buf_q[0];
                if (dataReadReq) exp_q.push_back(buf_q.pop_front());
            end
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_log.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, done_log.size() >= target, 1);
    endtask

    task automatic wait_tx_low(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, tx, 0);
    endtask

    initial begin : main
        int nf, nd, bad;
        tests = 0; fails = 0; cyc = 0;
        ack_always = 0; rand_ack = 0;
        reset = 1'b1; txEnable = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_req", dataReadReq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frameDone, 0);
        reset = 1'b0;

        txEnable = 1'b1;
        buf_q.push_back(8'h12);
        wait_done(1, 200, "single_0x12_done");

        nf = fall_log.size(); nd = done_log.size();
        buf_q.push_back(8'h12);
        buf_q.push_back(8'h23);
        wait_done(nd + 2, 300, "b2b_done");
        if (fall_log.size() >= nf + 2 && done_log.size() >= nd + 2)
            chk("b2b_gap", fall_log[nf+1] - done_log[nd], 2);
        else
            chk("b2b_logs", 0, 1);

        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(dataReadReq === 1'b1 && tx === 1'b1)) bad++;
            @(negedge clk);
        end
        chk("empty_wait_req_tx", bad, 0);
        nd = done_log.size();
        buf_q.push_back(8'hA5);
        wait_done(nd + 1, 200, "empty_then_a5_done");

        nd = done_log.size();
        rand_ack = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) buf_q.push_back(8'h07);
            else if (i == 1) buf_q.push_back(8'h03);
            else buf_q.push_back(8'($urandom));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_done(nd + 10, 2000, "random_done");
        rand_ack = 0;

        buf_q.push_back(8'hFF);
        wait_tx_low("rst_mid_start");
        repeat (17) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req", dataReadReq, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (frameDone !== 1'b0) bad++;
        end
        chk("rst_mid_no_done", bad, 0);
        reset = 1'b0;
        nd = done_log.size();
        buf_q.push_back(8'h3C);
        wait_done(nd + 1, 200, "after_rst_done");

        txEnable = 1'b0;
        repeat (3) @(negedge clk);
        ack_always = 1;
        buf_q.push_back(8'h5A);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dataReadReq !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("txen0_no_req", bad, 0);
        ack_always = 0;
        buf_q.delete();

        txEnable = 1'b1;
        nd = done_log.size();
        buf_q.push_back(8'h55);
        wait_tx_low("drop_start");
        repeat (10) @(negedge clk);
        txEnable = 1'b0;
        buf_q.push_back(8'h66);
        wait_done(nd + 1, 200, "drop_frame_done");
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dataReadReq !== 1'b0) bad++;
        end
        chk("drop_no_req", bad, 0);
        chk("drop_buf_left", buf_q.size(), 1);
        chk("drop_no_extra_frame", done_log.size(), nd + 1);
        buf_q.delete();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
